// File: rtl/jtkcpu_irqctl.sv
// Interrupt front end for the KONAMI-2 CPU: pin synchronisers, NMI latch/arming,
// reset > NMI > FIRQ > IRQ arbitration, request/ack handshake and SYNC/CWAI wake-up.
module jtkcpu_irqctl #(
  parameter int unsigned SYNC_STAGES = 2  // at least 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       nmi_n,
  input  logic       firq_n,
  input  logic       irq_n,
  input  logic       cc_f,
  input  logic       cc_i,
  input  logic       nmi_arm,
  input  logic       int_ack,
  input  logic       sync_wt,
  output logic       int_req,
  output logic [1:0] int_sel,
  output logic [3:0] int_vec,
  output logic       int_fast,
  output logic       wake
);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  localparam logic [1:0] SelReset = 2'd0;
  localparam logic [1:0] SelIrq   = 2'd1;
  localparam logic [1:0] SelFirq  = 2'd2;
  localparam logic [1:0] SelNmi   = 2'd3;

  logic [SYNC_STAGES-1:0] nmi_sync_q, firq_sync_q, irq_sync_q;
  logic                   nmi_s, firq_s, irq_s;
  logic                   nmi_prev_q, nmi_fall;
  logic                   nmi_armed_q, nmi_lat_q, nmi_lat_d;
  logic                   rst_req_q, ack_taken;
  logic                   cand_vld;
  logic [1:0]             cand_sel;
  logic [3:0]             cand_vec;
  state_e                 state_q, state_d;
  logic                   req_q, fast_q, fast_d, wake_q;
  logic [1:0]             sel_q, sel_d;
  logic [3:0]             vec_q, vec_d;

  assign nmi_s  = nmi_sync_q[SYNC_STAGES-1];
  assign firq_s = firq_sync_q[SYNC_STAGES-1];
  assign irq_s  = irq_sync_q[SYNC_STAGES-1];

  assign nmi_fall  = nmi_prev_q & ~nmi_s;
  assign ack_taken = cen & int_ack & (state_q == StReq);
  // A fresh edge in the ack cycle beats the clear, so that NMI is not lost.
  assign nmi_lat_d = (nmi_fall & nmi_armed_q) |
                     (nmi_lat_q & ~(ack_taken & (sel_q == SelNmi)));

  always_comb begin
    cand_vld = 1'b1;
    cand_sel = SelReset;
    if (rst_req_q) begin
      cand_sel = SelReset;
    end else if (nmi_lat_q) begin
      cand_sel = SelNmi;
    end else if (!firq_s && !cc_f) begin
      cand_sel = SelFirq;
    end else if (!irq_s && !cc_i) begin
      cand_sel = SelIrq;
    end else begin
      cand_vld = 1'b0;
    end
  end

  always_comb begin
    case (cand_sel)
      SelReset: cand_vec = 4'hE;
      SelIrq:   cand_vec = 4'h8;
      SelFirq:  cand_vec = 4'h6;
      default:  cand_vec = 4'hC;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    vec_d   = vec_q;
    fast_d  = fast_q;
    unique case (state_q)
      StIdle: begin
        if (cand_vld) state_d = StReq;
      end
      StReq: begin
        if (int_ack) begin
          state_d = StHold;
        end else if (!cand_vld) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Re-register the source every cycle the request stays up so it can be upgraded.
    if (state_d == StReq && !(state_q == StReq && int_ack)) begin
      sel_d  = cand_sel;
      vec_d  = cand_vec;
      fast_d = (cand_sel == SelFirq);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nmi_sync_q  <= '1;
      firq_sync_q <= '1;
      irq_sync_q  <= '1;
      nmi_prev_q  <= 1'b1;
      nmi_armed_q <= 1'b0;
      nmi_lat_q   <= 1'b0;
      rst_req_q   <= 1'b1;
      state_q     <= StReq;
      req_q       <= 1'b1;
      sel_q       <= SelReset;
      vec_q       <= 4'hE;
      fast_q      <= 1'b0;
      wake_q      <= 1'b0;
    end else if (cen) begin
      nmi_sync_q  <= {nmi_sync_q[SYNC_STAGES-2:0], nmi_n};
      firq_sync_q <= {firq_sync_q[SYNC_STAGES-2:0], firq_n};
      irq_sync_q  <= {irq_sync_q[SYNC_STAGES-2:0], irq_n};
      nmi_prev_q  <= nmi_s;
      nmi_armed_q <= nmi_armed_q | nmi_arm;
      nmi_lat_q   <= nmi_lat_d;
      rst_req_q   <= rst_req_q & ~(ack_taken & (sel_q == SelReset));
      state_q     <= state_d;
      req_q       <= (state_d == StReq);
      sel_q       <= sel_d;
      vec_q       <= vec_d;
      fast_q      <= fast_d;
      // Wake ignores the CC masks: a masked source still ends SYNC/CWAI.
      wake_q      <= sync_wt & (nmi_lat_q | ~firq_s | ~irq_s);
    end
  end

  assign int_req  = req_q;
  assign int_sel  = sel_q;
  assign int_vec  = vec_q;
  assign int_fast = fast_q;
  assign wake     = wake_q;

endmodule

// File: doc/jtkcpu_irqctl.md
Name: jtkcpu_irqctl

Overview:
Interrupt front end for the KONAMI-2 CPU core. Synchronises the external NMI/FIRQ/IRQ pins, applies CC masks, and latches and arms NMI. It arbitrates reset > NMI > FIRQ > IRQ and presents a single registered request, with source and vector, to the control unit. It runs the request/acknowledge handshake with the control unit at instruction boundaries and generates the SYNC/CWAI wake-up.

Parameters:
SYNC_STAGES, 2, synchroniser depth on each pin (minimum 2).

Ports:
clk      input   1  system clock
rst      input   1  asynchronous reset, active low
cen      input   1  clock enable; all state advances only when cen=1
nmi_n    input   1  NMI pin, falling-edge triggered
firq_n   input   1  FIRQ pin, level, active low
irq_n    input   1  IRQ pin, level, active low
cc_f     input   1  CC F bit; 1 masks FIRQ
cc_i     input   1  CC I bit; 1 masks IRQ
nmi_arm  input   1  one-cen pulse when S is first loaded; arms NMI
int_ack  input   1  one-cen pulse; control unit accepts the current request
sync_wt  input   1  control unit is in SYNC/CWAI wait
int_req  output  1  request pending (registered)
int_sel  output  2  source: 0 RESET, 1 IRQ, 2 FIRQ, 3 NMI
int_vec  output  4  vector low nibble; full address is FFF0+int_vec
int_fast output  1  FIRQ frame (push PC and CC only)
wake     output  1  release SYNC/CWAI

Behaviour:
- rst low (async): synchronisers load 1, nmi_armed=0, nmi_lat=0, state REQ, int_req=1, int_sel=0, int_vec=E, int_fast=0, wake=0.
- Synchroniser: pin captured at cen edge k; synced value valid at edge k+SYNC_STAGES-1. An nmi_n falling edge is detected on the synced value versus its previous value.
- NMI:
  - A detected edge sets nmi_lat only if nmi_armed.
  - Edges before arming are discarded, not held.
  - nmi_armed is set by nmi_arm and cleared only by rst.
  - nmi_lat clears on an int_ack taken with int_sel=3. An edge in the same cen cycle as that ack wins, so nmi_lat stays 1.
- Candidate each cen cycle, in priority order:
  - RESET, while the reset request is outstanding.
  - else NMI, if nmi_lat.
  - else FIRQ, if firq_s=0 and cc_f=0.
  - else IRQ, if irq_s=0 and cc_i=0.
  - else none.
- Vectors: RESET E, NMI C, FIRQ 6, IRQ 8. int_fast=1 only for FIRQ.
- FSM (transitions on cen):
  - IDLE: int_req=0. If a candidate exists, go to REQ and register int_sel/int_vec/int_fast.
  - REQ: int_req=1.
    - Outputs re-register every cen cycle, so a higher-priority source upgrades int_sel.
    - If the candidate disappears (e.g. irq_n released or cc_i set), go to IDLE with int_req=0 the next cycle.
    - If int_ack=1, go to HOLD. The serviced source is the int_sel value present in the ack cycle.
  - HOLD: int_req=0 for exactly one cen cycle (the control unit updates the masks), then go to IDLE.
    - The reset request clears on its ack.
    - Level sources still asserted and unmasked re-request from IDLE normally.
- int_ack in IDLE or HOLD is ignored with no state change.
- int_ack while cen=0 is ignored.
- Latency: firq_n/irq_n fall at edge k → int_req=1 after edge k+SYNC_STAGES, so 3 cen edges at default depth.
- wake (registered) = sync_wt and (nmi_lat or firq_s=0 or irq_s=0), regardless of cc_f/cc_i. It deasserts the cycle after sync_wt drops.
- rst mid-request: immediate return to the reset values above; a pending NMI is lost.

Test Plan:
- Reset release, no pins active → int_req=1, int_sel=0, int_vec=E. Pulse int_ack → int_req=0 for one cen, then IDLE with int_req=0.
- Falling nmi_n before nmi_arm → no request. Pulse nmi_arm, then a second falling nmi_n → int_req=1 at edge +3, int_sel=3, int_vec=C. After ack, nmi_lat clears and there is no re-request.
- irq_n=0, cc_i=0 → int_sel=1, int_vec=8. While in REQ, drive firq_n=0 with cc_f=0 → next cen int_sel=2, int_vec=6, int_fast=1. Ack → HOLD; then with cc_f=1 the IRQ re-requests.
- irq_n=0 with cc_i=1 → int_req stays 0. With sync_wt=1 → wake=1 next cen. Release irq_n → wake=0 after the synchroniser delay.
- NMI edge in the same cen cycle as an ack of NMI → nmi_lat stays set, and after HOLD int_req=1 with int_sel=3 again.
- Pull rst low while in REQ with int_sel=2 → outputs immediately int_req=1, int_sel=0, int_vec=E, int_fast=0. nmi_armed=0: a subsequent nmi_n edge without nmi_arm produces no request.
